// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake of the UART receive FIFO: head word plus its error flags, valid/ready.
// The receiver drives the master modport; the host-side consumer uses the slave modport.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, rx_perr, rx_ferr, rx_valid, input rx_ready);
    modport slave  (input rx_data, rx_perr, rx_ferr, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: 3-sample majority vote per bit, parity/framing/break/overrun detection.
// Each received word lands in a show-ahead FIFO that is read through a valid/ready interface.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMP   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        clk_sample_i,
    input  logic                        uart_rx_i,
    input  logic                        int_clear_n_i,
    uart_rx_fifo_if.master              rx_bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overrun_o,
    output logic                        break_o,
    output logic                        uart_rx_busy_o
);
    localparam int CW = $clog2(OVERSAMP);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_BITS + 2;
    localparam logic [CW-1:0] T_LO  = CW'(OVERSAMP / 2 - 1);
    localparam logic [CW-1:0] T_MID = CW'(OVERSAMP / 2);
    localparam logic [CW-1:0] T_HI  = CW'(OVERSAMP / 2 + 1);
    localparam logic [CW-1:0] T_END = CW'(OVERSAMP - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    // state      | meaning
    // ST_IDLE    | line idle, waiting for a falling edge seen on a sample tick
    // ST_START   | qualifying start bit, majority 1 means false start
    // ST_DATA    | shifting data bits in, LSB first
    // ST_PARITY  | capturing the parity bit
    // ST_STOP    | checking stop bit(s); frame completes mid last stop bit
    // ST_WAIT_HI | break seen, holding until the line returns high
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HI
    } state_t;

    state_t               state_q, state_nxt;
    logic                 rx_meta, rx_s, rx_last;
    logic [CW-1:0]        tick_cnt;
    logic                 s_lo, s_mid, maj;
    logic [DATA_BITS-1:0] shift_q;
    logic                 pbit_q, ferr_q, any_one_q, stop_idx;
    logic [3:0]           bit_idx;
    logic                 at_hi, at_end, last_stop;
    logic                 frame_done, brk_det, par_x, perr_calc;
    logic                 push_req;
    logic [WW-1:0]        push_word;

    assign maj       = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign at_hi     = clk_sample_i & (tick_cnt == T_HI);
    assign at_end    = clk_sample_i & (tick_cnt == T_END);
    assign last_stop = (STOP_BITS == 1) | stop_idx;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt  = state_q;
        frame_done = 1'b0;
        brk_det    = 1'b0;
        case (state_q)
            ST_IDLE:    if (clk_sample_i & rx_last & ~rx_s) state_nxt = ST_START;
            ST_START: begin
                if (at_hi & maj)  state_nxt = ST_IDLE;
                else if (at_end)  state_nxt = ST_DATA;
            end
            ST_DATA:    if (at_end && bit_idx == LAST_BIT)
                            state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY:  if (at_end) state_nxt = ST_STOP;
            ST_STOP: begin
                if (at_hi) begin
                    if (last_stop) begin
                        frame_done = 1'b1;
                        brk_det    = ~(any_one_q | maj);
                        state_nxt  = brk_det ? ST_WAIT_HI : ST_IDLE;
                    end
                end
            end
            ST_WAIT_HI: if (clk_sample_i & rx_s) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        par_x     = (^shift_q) ^ pbit_q;
        perr_calc = 1'b0;
        if (PARITY == 1)      perr_calc = par_x;
        else if (PARITY == 2) perr_calc = ~par_x;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_last   <= 1'b1;
            tick_cnt  <= '0;
            s_lo      <= 1'b0;
            s_mid     <= 1'b0;
            shift_q   <= '0;
            pbit_q    <= 1'b0;
            ferr_q    <= 1'b0;
            any_one_q <= 1'b0;
            stop_idx  <= 1'b0;
            bit_idx   <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            rx_meta  <= uart_rx_i;
            rx_s     <= rx_meta;
            push_req <= frame_done & ~brk_det;
            if (frame_done) push_word <= {ferr_q | ~maj, perr_calc, shift_q};
            if (clk_sample_i) begin
                rx_last <= rx_s;
                if (tick_cnt == T_LO)  s_lo  <= rx_s;
                if (tick_cnt == T_MID) s_mid <= rx_s;
                if (state_q == ST_IDLE || state_q == ST_WAIT_HI ||
                    state_nxt == ST_IDLE || state_nxt == ST_WAIT_HI || tick_cnt == T_END)
                    tick_cnt <= '0;
                else
                    tick_cnt <= tick_cnt + 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        ferr_q    <= 1'b0;
                        any_one_q <= 1'b0;
                        pbit_q    <= 1'b0;
                    end
                    ST_DATA: begin
                        if (tick_cnt == T_HI) begin
                            shift_q   <= {maj, shift_q[DATA_BITS-1:1]};
                            any_one_q <= any_one_q | maj;
                        end
                        if (tick_cnt == T_END) bit_idx <= bit_idx + 1'b1;
                    end
                    ST_PARITY: if (tick_cnt == T_HI) begin
                        pbit_q    <= maj;
                        any_one_q <= any_one_q | maj;
                    end
                    ST_STOP: begin
                        if (tick_cnt == T_HI) begin
                            ferr_q    <= ferr_q | ~maj;
                            any_one_q <= any_one_q | maj;
                        end
                        if (tick_cnt == T_END) stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          full, pop, push_ok, overrun_q, break_q;
    logic [WW-1:0] head;

    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign pop     = (level != '0) & rx_bus.rx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_req & (~full | pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (push_req & full & ~pop) overrun_q <= 1'b1;
            else if (!int_clear_n_i)    overrun_q <= 1'b0;
            if (brk_det)                break_q   <= 1'b1;
            else if (!int_clear_n_i)    break_q   <= 1'b0;
        end
    end

    assign rx_bus.rx_data  = head[DATA_BITS-1:0];
    assign rx_bus.rx_perr  = head[DATA_BITS];
    assign rx_bus.rx_ferr  = head[DATA_BITS+1];
    assign rx_bus.rx_valid = (level != '0);
    assign fifo_level_o    = level;
    assign overrun_o       = overrun_q;
    assign break_o         = break_q;
    assign uart_rx_busy_o  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three frame formats (8N1, 8E1, 7O2) driven from a vector
// table, plus hand-written sequences for false start, break, overrun and mid-frame reset.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_sample = 1'b0;
    logic int_clear_n = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [2:0] lvl_a, lvl_b, lvl_c;
    logic ovr_a, ovr_b, ovr_c, brk_a, brk_b, brk_c, busy_a, busy_b, busy_c;

    int n_pass = 0;
    int n_total = 0;

    uart_rx_fifo_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_fifo_if #(.DATA_BITS(8)) bus_b ();
    uart_rx_fifo_if #(.DATA_BITS(7)) bus_c ();

    uart_rx_fifo u_8n1 (
        .clk_i(clk), .reset_n_i(reset_n), .clk_sample_i(clk_sample), .uart_rx_i(rx_a),
        .int_clear_n_i(int_clear_n), .rx_bus(bus_a), .fifo_level_o(lvl_a),
        .overrun_o(ovr_a), .break_o(brk_a), .uart_rx_busy_o(busy_a));

    uart_rx_fifo #(.PARITY(1)) u_8e1 (
        .clk_i(clk), .reset_n_i(reset_n), .clk_sample_i(clk_sample), .uart_rx_i(rx_b),
        .int_clear_n_i(int_clear_n), .rx_bus(bus_b), .fifo_level_o(lvl_b),
        .overrun_o(ovr_b), .break_o(brk_b), .uart_rx_busy_o(busy_b));

    uart_rx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
        .clk_i(clk), .reset_n_i(reset_n), .clk_sample_i(clk_sample), .uart_rx_i(rx_c),
        .int_clear_n_i(int_clear_n), .rx_bus(bus_c), .fifo_level_o(lvl_c),
        .overrun_o(ovr_c), .break_o(brk_c), .uart_rx_busy_o(busy_c));

    always #5 clk = ~clk;
    // Sample tick every other clock: OVERSAMP*baud with one bit = 32 clocks.
    always @(negedge clk) clk_sample = ~clk_sample;

    initial begin
        bus_a.rx_ready = 1'b0;
        bus_b.rx_ready = 1'b0;
        bus_c.rx_ready = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic set_ready(input int sel, input logic v);
        case (sel)
            0: bus_a.rx_ready = v;
            1: bus_b.rx_ready = v;
            default: bus_c.rx_ready = v;
        endcase
    endtask

    task automatic get_head(input int sel, output logic [8:0] d, output logic pe, output logic fe,
                            output logic v, output logic [2:0] lvl);
        case (sel)
            0: begin d = {1'b0, bus_a.rx_data}; pe = bus_a.rx_perr; fe = bus_a.rx_ferr;
                     v = bus_a.rx_valid; lvl = lvl_a; end
            1: begin d = {1'b0, bus_b.rx_data}; pe = bus_b.rx_perr; fe = bus_b.rx_ferr;
                     v = bus_b.rx_valid; lvl = lvl_b; end
            default: begin d = {2'b00, bus_c.rx_data}; pe = bus_c.rx_perr; fe = bus_c.rx_ferr;
                     v = bus_c.rx_valid; lvl = lvl_c; end
        endcase
    endtask

    // sel 0: 8N1, sel 1: 8E1, sel 2: 7O2. Bits listed in line order, start bit first.
    function automatic void build(input int sel, input logic [8:0] data, input logic pbit,
                                  input logic [1:0] stops, output logic [15:0] bits, output int n);
        int nb = (sel == 2) ? 7 : 8;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin bits[n] = data[i]; n++; end
        if (sel != 0) begin bits[n] = pbit; n++; end
        bits[n] = stops[0]; n++;
        if (sel == 2) begin bits[n] = stops[1]; n++; end
    endfunction

    task automatic send_frame(input int sel, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops);
        logic [15:0] bits;
        int n;
        build(sel, data, pbit, stops, bits, n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            repeat (32) @(negedge clk);
        end
        set_rx(sel, 1'b1);
    endtask

    task automatic wait_valid(input int sel, output logic ok);
        logic [8:0] d; logic pe, fe, v; logic [2:0] l;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            get_head(sel, d, pe, fe, v, l);
            if (v) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pop_one(input int sel);
        set_ready(sel, 1'b1);
        @(negedge clk);
        set_ready(sel, 1'b0);
    endtask

    task automatic pulse_clear();
        int_clear_n = 1'b0;
        @(negedge clk);
        int_clear_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] d; logic pe, fe, v, ok, saw;
        logic [2:0] l;

        vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h055, 1'b0, 2'b10, 9'h055, 1'b0, 1'b1};
        vecs[3] = '{1, 9'h003, 1'b1, 2'b11, 9'h003, 1'b1, 1'b0};
        vecs[4] = '{1, 9'h003, 1'b0, 2'b11, 9'h003, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h080, 1'b0, 2'b11, 9'h080, 1'b1, 1'b0};
        vecs[6] = '{2, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
        vecs[7] = '{2, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b1, 1'b0};
        vecs[8] = '{2, 9'h015, 1'b0, 2'b11, 9'h015, 1'b0, 1'b0};
        vecs[9] = '{2, 9'h02A, 1'b0, 2'b01, 9'h02A, 1'b0, 1'b1};

        repeat (4) @(negedge clk);
        chk("reset_valid", {31'b0, bus_a.rx_valid}, 0);
        chk("reset_level", {29'b0, lvl_a}, 0);
        chk("reset_busy", {31'b0, busy_a}, 0);
        chk("reset_flags", {30'b0, ovr_a, brk_a}, 0);
        chk("reset_data", {24'b0, bus_a.rx_data}, 0);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            send_frame(vecs[k].sel, vecs[k].data, vecs[k].pbit, vecs[k].stops);
            wait_valid(vecs[k].sel, ok);
            chk($sformatf("vec%0d_valid", k), {31'b0, ok}, 1);
            get_head(vecs[k].sel, d, pe, fe, v, l);
            chk($sformatf("vec%0d_data", k), {23'b0, d}, {23'b0, vecs[k].exp_data});
            chk($sformatf("vec%0d_perr", k), {31'b0, pe}, {31'b0, vecs[k].exp_perr});
            chk($sformatf("vec%0d_ferr", k), {31'b0, fe}, {31'b0, vecs[k].exp_ferr});
            chk($sformatf("vec%0d_level", k), {29'b0, l}, 1);
            pop_one(vecs[k].sel);
            get_head(vecs[k].sel, d, pe, fe, v, l);
            chk($sformatf("vec%0d_level_after_pop", k), {29'b0, l}, 0);
            repeat (32) @(negedge clk);
        end

        // False start: low for 4 sample ticks only.
        saw = 1'b0;
        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        rx_a = 1'b1;
        repeat (60) @(negedge clk) if (busy_a) saw = 1'b1;
        chk("false_start_busy_seen", {31'b0, saw}, 1);
        chk("false_start_busy_end", {31'b0, busy_a}, 0);
        chk("false_start_level", {29'b0, lvl_a}, 0);

        // Break: line low for 20 bit times.
        rx_a = 1'b0;
        repeat (20 * 32) @(negedge clk);
        chk("break_busy_while_low", {31'b0, busy_a}, 1);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("break_flag", {31'b0, brk_a}, 1);
        chk("break_no_push", {29'b0, lvl_a}, 0);
        chk("break_busy_end", {31'b0, busy_a}, 0);
        pulse_clear();
        chk("break_cleared", {31'b0, brk_a}, 0);
        repeat (32) @(negedge clk);

        // Overrun: five frames back to back into a 4-deep FIFO with ready low.
        for (int k = 1; k <= 5; k++) send_frame(0, 9'(k), 1'b0, 2'b11);
        repeat (10) @(negedge clk);
        chk("overrun_level", {29'b0, lvl_a}, 4);
        chk("overrun_flag", {31'b0, ovr_a}, 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("overrun_pop%0d_data", k), {24'b0, bus_a.rx_data}, k);
            pop_one(0);
        end
        chk("overrun_drained", {29'b0, lvl_a}, 0);
        chk("overrun_still_set", {31'b0, ovr_a}, 1);
        pulse_clear();
        chk("overrun_cleared", {31'b0, ovr_a}, 0);
        repeat (32) @(negedge clk);

        // Reset during the data bits of 0x3C, then receive 0xC3.
        rx_a = 1'b0; repeat (32) @(negedge clk);
        rx_a = 1'b0; repeat (32) @(negedge clk);
        rx_a = 1'b0; repeat (32) @(negedge clk);
        rx_a = 1'b1; repeat (10) @(negedge clk);
        chk("pre_reset_busy", {31'b0, busy_a}, 1);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_reset_busy", {31'b0, busy_a}, 0);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(0, 9'h0C3, 1'b0, 2'b11);
        repeat (40) @(negedge clk);
        chk("post_reset_level", {29'b0, lvl_a}, 1);
        chk("post_reset_data", {24'b0, bus_a.rx_data}, 8'hC3);
        chk("post_reset_errs", {30'b0, bus_a.rx_perr, bus_a.rx_ferr}, 0);
        chk("post_reset_flags", {30'b0, ovr_a, brk_a}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
